onchip_mem_fill_check: RTL and testbench

- Avalon-MM initiator that drives the single-port on-chip RAM slave: fills a word range with a deterministic pattern, reads it back and compares.
- Used for power-on memory test and for frame-buffer clearing before the video pipeline starts.
- Sits between a control register block (start/config/status) and the RAM's s1 port.
- Targets a zero-wait-state slave with fixed read latency; there is no waitrequest.

---
 rtl/onchip_mem_fill_check.sv | 277 +++++++++++++++++++++++++++
 tb/tb_onchip_mem_fill_check.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_fill_check.sv
// onchip_mem_fill_check
//
// Avalon-MM initiator for a zero-wait-state, fixed-read-latency on-chip RAM.
// It fills a word range with the pattern seed + i, reads the range back and
// compares each word against the same pattern. It is used for the power-on
// memory test and for clearing frame buffers.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted only in idle
//   abort                 level, stops issuing new accesses in write/read
//   mode                  00 fill+check, 01 fill only, 10 check only, 11 = 00
//   base_addr/length/seed run configuration, latched on an accepted start
//   address, byteenable,
//   chipselect, write,
//   writedata, clken      Avalon-MM initiator side towards the RAM s1 port
//   readdata              RAM read data, valid READ_LATENCY cycles after issue
//   busy, done, pass,
//   range_err, aborted,
//   err_count,
//   first_err_addr        status towards the control register block

module onchip_mem_fill_check #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_DEPTH    = 25000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ERR_W        = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                range_err,
    output logic                aborted,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned SUM_W = ADDR_W + 2;
    localparam int unsigned RL    = READ_LATENCY;

    typedef enum logic [2:0] {
        StIdle,
        StCheckRange,
        StWrite,
        StRead,
        StDrain,
        StFinish
    } state_e;

    // Reset: asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic                pass_q, pass_d;
    logic                range_err_q, range_err_d;
    logic                aborted_q, aborted_d;

    // Read pipe: expected word and its address travel alongside the RAM latency.
    logic [RL-1:0]       pipe_vld_q;
    logic [DATA_W-1:0]   pipe_exp_q  [RL];
    logic [ADDR_W-1:0]   pipe_addr_q [RL];

    logic                issue;
    logic                rd_issue;
    logic                last_word;
    logic                range_bad;
    logic                pipe_empty;
    logic                mismatch;
    logic [SUM_W-1:0]    range_end;
    logic [DATA_W-1:0]   pattern;
    logic [ADDR_W-1:0]   cur_addr;

    // Abort suppresses the access in the very cycle it is seen.
    assign issue     = ((state_q == StWrite) || (state_q == StRead)) && !abort;
    assign rd_issue  = issue && (state_q == StRead);
    assign last_word = (idx_q == (len_q - LEN_W'(1)));
    assign range_end = SUM_W'(base_q) + SUM_W'(len_q);
    assign range_bad = range_end > SUM_W'(MEM_DEPTH);
    assign pattern   = seed_q + DATA_W'(idx_q);
    assign cur_addr  = base_q + idx_q[ADDR_W-1:0];

    assign pipe_empty = (pipe_vld_q == '0);
    assign mismatch   = pipe_vld_q[RL-1] && (readdata != pipe_exp_q[RL-1]);

    // Bus outputs
    assign chipselect = issue;
    assign write      = issue && (state_q == StWrite);
    assign address    = issue ? cur_addr : '0;
    assign writedata  = write ? pattern : '0;
    assign byteenable = {BE_W{issue}};
    assign clken      = 1'b1;

    // Status outputs
    assign busy           = (state_q != StIdle) && (state_q != StFinish);
    assign done           = (state_q == StFinish);
    assign pass           = pass_q;
    assign range_err      = range_err_q;
    assign aborted        = aborted_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            mode_q           <= 2'b00;
            base_q           <= '0;
            len_q            <= '0;
            seed_q           <= '0;
            idx_q            <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            pass_q           <= 1'b0;
            range_err_q      <= 1'b0;
            aborted_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            base_q           <= base_d;
            len_q            <= len_d;
            seed_q           <= seed_d;
            idx_q            <= idx_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            pass_q           <= pass_d;
            range_err_q      <= range_err_d;
            aborted_q        <= aborted_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(RL); i++) begin
                pipe_exp_q[i]  <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= rd_issue;
            pipe_exp_q[0]  <= pattern;
            pipe_addr_q[0] <= cur_addr;
            for (int i = 1; i < int'(RL); i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        base_d           = base_q;
        len_d            = len_q;
        seed_d           = seed_q;
        idx_d            = idx_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        pass_d           = pass_q;
        range_err_d      = range_err_q;
        aborted_d        = aborted_q;

        // Compare reads leaving the pipe; a zero count marks the first mismatch.
        if (mismatch) begin
            if (err_count_q == '0) begin
                first_err_addr_d = pipe_addr_q[RL-1];
            end
            if (err_count_q != {ERR_W{1'b1}}) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d           = mode;
                    base_d           = base_addr;
                    len_d            = length;
                    seed_d           = seed;
                    idx_d            = '0;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    pass_d           = 1'b0;
                    range_err_d      = 1'b0;
                    aborted_d        = 1'b0;
                    state_d          = StCheckRange;
                end
            end
            StCheckRange: begin
                idx_d = '0;
                if (len_q == '0) begin
                    state_d = StFinish;
                end else if (range_bad) begin
                    range_err_d = 1'b1;
                    state_d     = StFinish;
                end else if (mode_q == 2'b10) begin
                    state_d = StRead;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDrain;
                end else if (last_word) begin
                    idx_d   = '0;
                    state_d = (mode_q == 2'b01) ? StFinish : StRead;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            StRead: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDrain;
                end else if (last_word) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            StDrain: begin
                if (pipe_empty) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Verdict is registered on entry to finish so it is valid alongside done.
        if ((state_d == StFinish) && (state_q != StFinish)) begin
            pass_d = (err_count_d == '0) && !range_err_d && !aborted_d;
        end
    end

endmodule

// File: tb/tb_onchip_mem_fill_check.sv
module tb_onchip_mem_fill_check;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 25000;
    localparam int ERR_W     = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start1 = 1'b0;
    logic              start3 = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic [DATA_W-1:0] seed = '0;

    logic [ADDR_W-1:0] a1, a3;
    logic [3:0]        be1, be3;
    logic              cs1, cs3, wr1, wr3, ck1, ck3;
    logic [DATA_W-1:0] wd1, wd3, rdata1, rdata3;
    logic              busy1, busy3, done1, done3, pass1, pass3;
    logic              re1, re3, ab1, ab3;
    logic [ERR_W-1:0]  ec1, ec3;
    logic [ADDR_W-1:0] fe1, fe3;

    always #5 clk = ~clk;

    onchip_mem_fill_check #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed), .address(a1),
        .byteenable(be1), .chipselect(cs1), .write(wr1), .writedata(wd1), .clken(ck1),
        .readdata(rdata1), .busy(busy1), .done(done1), .pass(pass1), .range_err(re1),
        .aborted(ab1), .err_count(ec1), .first_err_addr(fe1)
    );

    onchip_mem_fill_check #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .abort(abort), .mode(mode),
        .base_addr(base_addr), .length(length), .seed(seed), .address(a3),
        .byteenable(be3), .chipselect(cs3), .write(wr3), .writedata(wd3), .clken(ck3),
        .readdata(rdata3), .busy(busy3), .done(done3), .pass(pass3), .range_err(re3),
        .aborted(ab3), .err_count(ec3), .first_err_addr(fe3)
    );

    // Shared RAM model; each DUT gets a read path with its own latency.
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              fault_en = 1'b0;
    logic [ADDR_W-1:0] fault_addr = '0;
    logic [DATA_W-1:0] rd1_q = '0;
    logic [DATA_W-1:0] rd3_q [3];

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < 3; i++) rd3_q[i] = '0;
    end

    function automatic logic [DATA_W-1:0] ram_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = (int'(a) < MEM_DEPTH) ? mem[a] : '0;
        if (fault_en && (a == fault_addr)) v[0] = ~v[0];
        return v;
    endfunction

    always @(posedge clk) begin
        if (cs1 && wr1) mem[a1] <= wd1;
        if (cs3 && wr3) mem[a3] <= wd3;
        if (cs1 && !wr1) rd1_q <= ram_read(a1);
        if (cs3 && !wr3) rd3_q[0] <= ram_read(a3);
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end

    assign rdata1 = rd1_q;
    assign rdata3 = rd3_q[2];

    // Scoreboard
    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;

    typedef struct {
        int                lat;
        logic              pass;
        logic              range_err;
        logic              aborted;
        logic [ERR_W-1:0]  err;
        logic [ADDR_W-1:0] first;
    } res_t;

    acc_t acc_q[$];
    res_t res_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_access(input string who, input logic wr, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [3:0] be);
        acc_t e;
        tests++;
        assert (acc_q.size() > 0) else begin
            fails++;
            $error("FAIL %s_unexpected_access: observed access at %0h, expected none", who, a);
        end
        if (acc_q.size() > 0) begin
            e = acc_q.pop_front();
            chk({who, "_write"}, 64'(wr), 64'(e.wr));
            chk({who, "_addr"}, 64'(a), 64'(e.addr));
            if (e.wr) chk({who, "_wdata"}, 64'(d), 64'(e.data));
            chk({who, "_byteenable"}, 64'(be), 64'hf);
        end
    endtask

    task automatic check_result(input logic p, input logic re, input logic ab,
                                input logic [ERR_W-1:0] ec, input logic [ADDR_W-1:0] fe);
        res_t r;
        tests++;
        assert (res_q.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_done: observed done at cycle %0d, expected none", cyc);
        end
        if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("done_latency", 64'(cyc - start_cyc), 64'(r.lat));
            chk("pass", 64'(p), 64'(r.pass));
            chk("range_err", 64'(re), 64'(r.range_err));
            chk("aborted", 64'(ab), 64'(r.aborted));
            chk("err_count", 64'(ec), 64'(r.err));
            chk("first_err_addr", 64'(fe), 64'(r.first));
        end
    endtask

    always @(negedge clk) begin
        if (cs1) check_access("dut1", wr1, a1, wd1, be1);
        if (cs3) check_access("dut3", wr3, a3, wd3, be3);
        if (done1 || done3) begin
            done_cnt++;
            if (done1) check_result(pass1, re1, ab1, ec1, fe1);
            else       check_result(pass3, re3, ab3, ec3, fe3);
        end
    end

    task automatic push_acc(input logic wr, input int b, input int n, input logic [31:0] sd);
        acc_t e;
        for (int i = 0; i < n; i++) begin
            e.wr   = wr;
            e.addr = ADDR_W'(b + i);
            e.data = wr ? sd + 32'(i) : '0;
            acc_q.push_back(e);
        end
    endtask

    task automatic push_res(input int lat, input logic p, input logic re, input logic ab,
                            input int ec, input int fe);
        res_t r;
        r.lat = lat; r.pass = p; r.range_err = re; r.aborted = ab;
        r.err = ERR_W'(ec); r.first = ADDR_W'(fe);
        res_q.push_back(r);
    endtask

    task automatic config_run(input logic [1:0] m, input int b, input int n, input logic [31:0] sd);
        mode = m; base_addr = ADDR_W'(b); length = (ADDR_W+1)'(n); seed = sd;
    endtask

    task automatic pulse_start(input bit use3);
        @(posedge clk); #1;
        start_cyc = cyc;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        tests++;
        assert (done_cnt != n0) else begin
            fails++;
            $error("FAIL done_timeout: observed no done in %0d cycles, expected done", budget);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(acc_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        bit  found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chipselect", 64'(cs1), 64'd0);
        chk("rst_byteenable", 64'(be1), 64'd0);
        chk("rst_address", 64'(a1), 64'd0);
        chk("rst_writedata", 64'(wd1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_pass", 64'(pass1), 64'd0);
        chk("rst_err_count", 64'(ec1), 64'd0);
        chk("rst_clken", 64'(ck1), 64'd1);
        chk("rst_chipselect_rl3", 64'(cs3), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Fill+check, 8 words
        config_run(2'b00, 0, 8, 32'h100);
        push_acc(1'b1, 0, 8, 32'h100);
        push_acc(1'b0, 0, 8, 32'h100);
        push_res(20, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse_start(1'b0);
        #1 chk("busy_during_run", 64'(busy1), 64'd1);
        wait_done(60);
        chk("pass_held", 64'(pass1), 64'd1);
        chk("busy_after_done", 64'(busy1), 64'd0);

        // Bit flip on word 5
        fault_en = 1'b1; fault_addr = 15'd5;
        config_run(2'b00, 0, 16, 32'h2000);
        push_acc(1'b1, 0, 16, 32'h2000);
        push_acc(1'b0, 0, 16, 32'h2000);
        push_res(36, 1'b0, 1'b0, 1'b0, 1, 5);
        pulse_start(1'b0);
        wait_done(80);
        fault_en = 1'b0;

        // Range rejected, then zero length
        config_run(2'b00, 24990, 20, 32'h0);
        push_res(2, 1'b0, 1'b1, 1'b0, 0, 0);
        pulse_start(1'b0);
        wait_done(20);
        chk("range_err_held", 64'(re1), 64'd1);

        config_run(2'b00, 0, 0, 32'h0);
        push_res(2, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse_start(1'b0);
        wait_done(20);

        // Abort at the 10th read; the read of word 8 is still in flight and corrupted
        fault_en = 1'b1; fault_addr = 15'd8;
        config_run(2'b00, 0, 100, 32'h5000);
        push_acc(1'b1, 0, 100, 32'h5000);
        push_acc(1'b0, 0, 9, 32'h5000);
        push_res(113, 1'b0, 1'b0, 1'b1, 1, 8);
        pulse_start(1'b0);
        repeat (110) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(40);
        fault_en = 1'b0;

        // Reset in the middle of a fill
        config_run(2'b01, 32'h40, 10, 32'h77);
        push_acc(1'b1, 32'h40, 4, 32'h77);
        pulse_start(1'b0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (cs1 && (a1 == 15'h43)) found = 1'b1;
        end
        chk("reached_word3", 64'(found), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_drops_chipselect", 64'(cs1), 64'd0);
        chk("reset_drops_busy", 64'(busy1), 64'd0);
        n0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt), 64'(n0));
        chk("reset_mid_run_accesses", 64'(acc_q.size()), 64'd0);

        // Pattern wraps at 2^32
        config_run(2'b00, 32'h10, 2, 32'hFFFF_FFFF);
        push_acc(1'b1, 32'h10, 2, 32'hFFFF_FFFF);
        push_acc(1'b0, 32'h10, 2, 32'hFFFF_FFFF);
        push_res(8, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse_start(1'b0);
        wait_done(30);

        // Preload, then check-only on the latency-3 instance with an ignored restart
        config_run(2'b01, 200, 4, 32'hA000);
        push_acc(1'b1, 200, 4, 32'hA000);
        push_res(6, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse_start(1'b0);
        wait_done(30);

        config_run(2'b10, 200, 4, 32'hA000);
        push_acc(1'b0, 200, 4, 32'hA000);
        push_res(10, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse_start(1'b1);
        @(posedge clk);
        #1;
        chk("rl3_busy", 64'(busy3), 64'd1);
        config_run(2'b00, 0, 1, 32'h0);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        wait_done(40);
        n0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("single_done_rl3", 64'(done_cnt), 64'(n0));

        // Mode 11 behaves as fill+check
        config_run(2'b11, 300, 3, 32'h1234);
        push_acc(1'b1, 300, 3, 32'h1234);
        push_acc(1'b0, 300, 3, 32'h1234);
        push_res(10, 1'b1, 1'b0, 1'b0, 0, 0);
        pulse_start(1'b0);
        wait_done(30);

        chk("results_drained", 64'(res_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
